f_spsram_arb2: RTL and testbench
================================

Name: f_spsram_arb2

Overview:
- Two-requester round-robin arbiter/sequencer for the 16384x128 single-port SRAM macro (byte-write, active-low CEN/WEN, registered Q).
- Converts two valid/ready request ports (read or byte-masked write) into SRAM pin activity.
- Returns read data with 1-cycle latency and per-port response handshakes.
- Sits between the AXI-to-SRAM bridge channels, e.g. read channel on port 0 and write channel on port 1, and the SRAM instance.

Parameters:
- AW, 14, SRAM word-address width.
- DW, 128, data width in bits; byte lanes are DW/8 = 16.

Ports:
- CLK  in  1  clock; everything is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- pN_req_valid  in  1  port N (N=0,1) request valid.
- pN_req_ready  out  1  port N request accepted this cycle.
- pN_req_write  in  1  1 = write, 0 = read.
- pN_req_addr  in  AW  word address.
- pN_req_wdata  in  DW  write data.
- pN_req_wstrb  in  DW/8  active-high byte strobes.
- pN_rsp_valid  out  1  read data valid for port N.
- pN_rsp_ready  in  1  port N accepts response.
- rsp_data  out  DW  shared read data; equals sram_q, meaningful only while a pN_rsp_valid is high.
- sram_a  out  AW  to SRAM A.
- sram_cen  out  1  to SRAM CEN (active-low).
- sram_d  out  DW  to SRAM D.
- sram_wen  out  DW/8  to SRAM WEN (active-low per byte).
- sram_q  in  DW  from SRAM Q.

Behaviour:
- SRAM pins are driven combinationally from the granted request. The SRAM samples at the same edge where the req handshake completes.
- State registers:
  - rr_ptr: preferred port.
  - rd_pend: read response outstanding.
  - rd_id: port owning the outstanding response.
- Reset (RST=1 at an edge): rr_ptr=0, rd_pend=0, rd_id=0. While RST=1, all pN_req_ready=0, sram_cen=1 and sram_wen=all ones.
- Outputs after reset: pN_rsp_valid=0, sram_a=0, sram_d=0.
- Eligibility:
  - A write is always eligible.
  - A read is eligible only if rd_pend=0, or the outstanding response is being accepted this cycle (p[rd_id]_rsp_ready=1).
- Arbitration:
  - If only one port is valid and eligible, it is granted.
  - If both are, port rr_ptr is granted.
  - After any grant, rr_ptr <= ~granted port. With no grant, rr_ptr is held.
  - pN_req_ready = grant to N. At most one grant per cycle.
- Granted read: sram_cen=0, sram_wen=all ones, sram_a=addr. Next cycle rd_pend=1 and rd_id=N.
- Granted write with wstrb!=0: sram_cen=0, sram_wen=~wstrb, sram_d=wdata, sram_a=addr. rd_pend is unaffected; there is no write response.
- Granted write with wstrb==0: the request is accepted, but sram_cen stays 1. Asserting CEN with all-ones WEN would perform a read and corrupt a held Q.
- Idle (no grant): sram_cen=1, sram_wen=all ones, sram_a/sram_d hold the last value.
- Response path:
  - pN_rsp_valid = rd_pend && rd_id==N; rsp_data = sram_q.
  - The response holds until pN_rsp_ready. Q is stable meanwhile because no read is issued and writes do not alter Q.
- rd_pend update:
  - Cleared on rsp handshake, unless a new read is granted in the same cycle; then it stays 1 and rd_id is updated.
  - Back-to-back reads from one port with rsp_ready=1 give one read per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (SRAM write completes at the earlier edge).
- Same-cycle conflicting requests to one address: round-robin order decides; no forwarding.
- Reset mid-operation: a pending response is dropped. The port must re-issue.
- Request inputs must be held stable while pN_req_valid=1 and not ready. The bench checks this; RTL does not.

Test Plan:
1. Reset, then p0 writes addr 0x0005, data 0x00112233_44556677_8899AABB_CCDDEEFF, wstrb 0xFFFF. Next cycle p0 reads 0x0005 → p0_rsp_valid one cycle after accept with that data. sram_wen=0x0000 on the write, 0xFFFF on the read.
2. Partial write to 0x0005 with wstrb 0x0001, data LSB 0xA5 → readback 0x00112233_44556677_8899AABB_CCDDEEA5. A wstrb=0 write is accepted with sram_cen=1 throughout and Q unchanged.
3. Both ports valid with reads every cycle, rsp_ready=1 → grants alternate 0,1,0,1 starting at 0 after reset. Throughput is one read per cycle; rsp_valid follows on the correct port.
4. p0 read outstanding with p0_rsp_ready=0 for 5 cycles while p1 reads → p1 not granted and rsp_data stable. p1 writes are accepted meanwhile. p1 is granted in the cycle p0_rsp_ready=1.
5. Write 0xDEAD… to 0x3FFF, then read 0x3FFF in the next cycle → new data returned (top-address boundary, RAW).
6. Assert RST while p1 response pending → p1_rsp_valid=0, rr_ptr=0 and sram_cen=1 the cycle after. Normal operation resumes after RST deasserts.

Source files
------------

// File: rtl/f_spsram_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : f_spsram_arb2
//  Description : Two-requester round-robin arbiter/sequencer in front of a
//                16384x128 single-port SRAM macro (byte write, active-low
//                CEN/WEN, registered Q). Each port issues reads or
//                byte-masked writes over valid/ready. Read data returns one
//                cycle after acceptance on a per-port response handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST          clock (rising edge), synchronous active-high reset
//    pN_req_valid      port N request valid                        (N = 0,1)
//    pN_req_ready      port N request accepted this cycle
//    pN_req_write      1 = write, 0 = read
//    pN_req_addr       word address
//    pN_req_wdata      write data
//    pN_req_wstrb      active-high byte strobes
//    pN_rsp_valid      read data valid for port N
//    pN_rsp_ready      port N accepts the response
//    rsp_data          shared read data (SRAM Q), valid with a pN_rsp_valid
//    sram_a/cen/d/wen  SRAM macro inputs (CEN, WEN active-low)
//    sram_q            SRAM macro registered output
// ============================================================================
module f_spsram_arb2 #(
  parameter int AW = 14,
  parameter int DW = 128
) (
  input  logic            CLK,
  input  logic            RST,
  // port 0 request / response
  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic            p0_req_write,
  input  logic [AW-1:0]   p0_req_addr,
  input  logic [DW-1:0]   p0_req_wdata,
  input  logic [DW/8-1:0] p0_req_wstrb,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  // port 1 request / response
  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic            p1_req_write,
  input  logic [AW-1:0]   p1_req_addr,
  input  logic [DW-1:0]   p1_req_wdata,
  input  logic [DW/8-1:0] p1_req_wstrb,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  // shared read data
  output logic [DW-1:0]   rsp_data,
  // SRAM macro
  output logic [AW-1:0]   sram_a,
  output logic            sram_cen,
  output logic [DW-1:0]   sram_d,
  output logic [DW/8-1:0] sram_wen,
  input  logic [DW-1:0]   sram_q
);

  localparam int BW = DW / 8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          r_rr_ptr;   // preferred port when both are eligible
  logic          r_rd_pend;  // a read response is outstanding
  logic          r_rd_id;    // port owning the outstanding response
  logic [AW-1:0] r_a_last;   // SRAM address held while idle
  logic [DW-1:0] r_d_last;   // SRAM data held while idle

  // --------------------------------------------------------------------------
  // Eligibility and arbitration
  // --------------------------------------------------------------------------
  logic w_rsp_hs;    // outstanding response is accepted this cycle
  logic w_rd_ok;     // a new read may be issued this cycle
  logic w_cand0;
  logic w_cand1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;

  assign w_rsp_hs = r_rd_pend && (r_rd_id ? p1_rsp_ready : p0_rsp_ready);

  // Q is the only read-data storage, so a new read may only be launched once
  // the previous response is gone or leaving in this very cycle.
  assign w_rd_ok  = !r_rd_pend || w_rsp_hs;

  assign w_cand0  = !RST && p0_req_valid && (p0_req_write || w_rd_ok);
  assign w_cand1  = !RST && p1_req_valid && (p1_req_write || w_rd_ok);

  assign w_gnt0   = w_cand0 && (!w_cand1 || !r_rr_ptr);
  assign w_gnt1   = w_cand1 && (!w_cand0 ||  r_rr_ptr);
  assign w_gnt_any = w_gnt0 || w_gnt1;

  assign p0_req_ready = w_gnt0;
  assign p1_req_ready = w_gnt1;

  // --------------------------------------------------------------------------
  // Granted request mux
  // --------------------------------------------------------------------------
  logic          w_gnt_write;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic [BW-1:0] w_gnt_wstrb;
  logic          w_issue_rd;
  logic          w_issue_wr;
  logic          w_issue;

  assign w_gnt_write = w_gnt1 ? p1_req_write : p0_req_write;
  assign w_gnt_addr  = w_gnt1 ? p1_req_addr  : p0_req_addr;
  assign w_gnt_wdata = w_gnt1 ? p1_req_wdata : p0_req_wdata;
  assign w_gnt_wstrb = w_gnt1 ? p1_req_wstrb : p0_req_wstrb;

  assign w_issue_rd  = w_gnt_any && !w_gnt_write;
  // An all-zero strobe write is swallowed: enabling the macro with all-ones
  // WEN would be a read and would overwrite a Q value still being returned.
  assign w_issue_wr  = w_gnt_any &&  w_gnt_write && (|w_gnt_wstrb);
  assign w_issue     = w_issue_rd || w_issue_wr;

  // --------------------------------------------------------------------------
  // SRAM pins (combinational from the grant; the macro samples at the same
  // edge that completes the request handshake)
  // --------------------------------------------------------------------------
  assign sram_cen = !w_issue;
  assign sram_wen = w_issue_wr ? ~w_gnt_wstrb : {BW{1'b1}};
  assign sram_a   = w_issue    ? w_gnt_addr   : r_a_last;
  assign sram_d   = w_issue_wr ? w_gnt_wdata  : r_d_last;

  // --------------------------------------------------------------------------
  // Response path: Q is held by the macro while no read is issued, so it can
  // be presented directly for as long as the response waits.
  // --------------------------------------------------------------------------
  assign p0_rsp_valid = r_rd_pend && !r_rd_id;
  assign p1_rsp_valid = r_rd_pend &&  r_rd_id;
  assign rsp_data     = sram_q;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
      r_a_last  <= '0;
      r_d_last  <= '0;
    end else begin
      // Hand preference to the other port after every grant.
      if (w_gnt0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_rr_ptr <= 1'b0;
      end

      // A new read takes priority over clearing: back-to-back reads keep
      // the pending flag set and move ownership to the new requester.
      if (w_issue_rd) begin
        r_rd_pend <= 1'b1;
        r_rd_id   <= w_gnt1;
      end else if (w_rsp_hs) begin
        r_rd_pend <= 1'b0;
      end

      if (w_issue) begin
        r_a_last <= w_gnt_addr;
      end
      if (w_issue_wr) begin
        r_d_last <= w_gnt_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_spsram_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f_spsram_arb2
//  Description : Directed self-checking bench for f_spsram_arb2 with a
//                behavioural 16384x128 byte-write SRAM macro attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_f_spsram_arb2;

  localparam int AW = 14;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic          CLK;
  logic          RST;
  logic          p0_req_valid, p0_req_ready, p0_req_write;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic [BW-1:0] p0_req_wstrb;
  logic          p0_rsp_valid, p0_rsp_ready;
  logic          p1_req_valid, p1_req_ready, p1_req_write;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic [BW-1:0] p1_req_wstrb;
  logic          p1_rsp_valid, p1_rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic [DW-1:0] sram_d;
  logic [BW-1:0] sram_wen;
  logic [DW-1:0] sram_q;

  int tests;
  int fails;

  localparam logic [DW-1:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] DP = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFA5;
  localparam logic [DW-1:0] D2 = 128'h00112233_44556677_8899AABB_CCDDEEA5;
  localparam logic [DW-1:0] D3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [DW-1:0] D4 = 128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0;
  localparam logic [DW-1:0] D5 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  f_spsram_arb2 #(.AW(AW), .DW(DW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_write (p0_req_write),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_req_wstrb (p0_req_wstrb),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_write (p1_req_write),
    .p1_req_addr  (p1_req_addr),
    .p1_req_wdata (p1_req_wdata),
    .p1_req_wstrb (p1_req_wstrb),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .rsp_data     (rsp_data),
    .sram_a       (sram_a),
    .sram_cen     (sram_cen),
    .sram_d       (sram_d),
    .sram_wen     (sram_wen),
    .sram_q       (sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Behavioural SRAM macro: registered Q updated by reads only
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_q = '0;
  end

  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (&sram_wen) begin
        sram_q <= mem[sram_a];
      end else begin
        for (int b = 0; b < BW; b++) begin
          if (!sram_wen[b]) mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stalled requests must be held stable until accepted.
  logic          h0_stall, h1_stall;
  logic [30:0]   h0_req, h1_req;

  initial begin
    h0_stall = 1'b0;
    h1_stall = 1'b0;
    h0_req   = '0;
    h1_req   = '0;
  end

  always @(posedge CLK) begin
    if (h0_stall && p0_req_valid) chk("hold0", {p0_req_write, p0_req_addr, p0_req_wstrb}, h0_req);
    if (h1_stall && p1_req_valid) chk("hold1", {p1_req_write, p1_req_addr, p1_req_wstrb}, h1_req);
    h0_stall <= p0_req_valid && !p0_req_ready && !RST;
    h1_stall <= p1_req_valid && !p1_req_ready && !RST;
    h0_req   <= {p0_req_write, p0_req_addr, p0_req_wstrb};
    h1_req   <= {p1_req_write, p1_req_addr, p1_req_wstrb};
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge,
  // outputs are checked 4 time units after the edge.
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic req0(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] s);
    p0_req_valid = v; p0_req_write = w; p0_req_addr = a;
    p0_req_wdata = d; p0_req_wstrb = s;
  endtask

  task automatic req1(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] s);
    p1_req_valid = v; p1_req_write = w; p1_req_addr = a;
    p1_req_wdata = d; p1_req_wstrb = s;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b1;
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    req0(1'b0, 1'b0, '0, '0, '0);
    req1(1'b0, 1'b0, '0, '0, '0);

    // ---------------- reset behaviour ----------------
    cyc(); cyc();
    req0(1'b1, 1'b1, 14'h0005, D1, 16'hFFFF);
    settle();
    chk("rst_ready0", p0_req_ready, 1'b0);
    chk("rst_cen",    sram_cen,     1'b1);
    chk("rst_wen",    sram_wen,     16'hFFFF);
    req0(1'b0, 1'b0, '0, '0, '0);
    RST = 1'b0;
    cyc();
    settle();
    chk("post_rsp_v0", p0_rsp_valid, 1'b0);
    chk("post_rsp_v1", p1_rsp_valid, 1'b0);
    chk("post_a",      sram_a,       '0);
    chk("post_d",      sram_d,       '0);
    chk("post_cen",    sram_cen,     1'b1);

    // ---------------- 1: full write then read ----------------
    cyc();
    req0(1'b1, 1'b1, 14'h0005, D1, 16'hFFFF);
    settle();
    chk("t1_wr_ready", p0_req_ready, 1'b1);
    chk("t1_wr_cen",   sram_cen,     1'b0);
    chk("t1_wr_wen",   sram_wen,     16'h0000);
    chk("t1_wr_a",     sram_a,       14'h0005);
    chk("t1_wr_d",     sram_d,       D1);
    cyc();
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    settle();
    chk("t1_rd_ready", p0_req_ready, 1'b1);
    chk("t1_rd_cen",   sram_cen,     1'b0);
    chk("t1_rd_wen",   sram_wen,     16'hFFFF);
    chk("t1_rd_rspv",  p0_rsp_valid, 1'b0);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    p0_rsp_ready = 1'b1;
    settle();
    chk("t1_rsp_v0",   p0_rsp_valid, 1'b1);
    chk("t1_rsp_v1",   p1_rsp_valid, 1'b0);
    chk("t1_rsp_data", rsp_data,     D1);
    chk("t1_idle_cen", sram_cen,     1'b1);
    chk("t1_idle_a",   sram_a,       14'h0005);
    cyc();
    settle();
    chk("t1_rsp_done", p0_rsp_valid, 1'b0);

    // ---------------- 2: partial write, zero-strobe write ----------------
    cyc();
    req0(1'b1, 1'b1, 14'h0005, DP, 16'h0001);
    settle();
    chk("t2_pw_ready", p0_req_ready, 1'b1);
    chk("t2_pw_wen",   sram_wen,     16'hFFFE);
    cyc();
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    settle();
    chk("t2_rd_ready", p0_req_ready, 1'b1);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t2_rsp_v0",   p0_rsp_valid, 1'b1);
    chk("t2_rsp_data", rsp_data,     D2);
    cyc();
    req0(1'b1, 1'b1, 14'h0005, '0, 16'h0000);
    settle();
    chk("t2_z_ready",  p0_req_ready, 1'b1);
    chk("t2_z_cen",    sram_cen,     1'b1);
    chk("t2_z_wen",    sram_wen,     16'hFFFF);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t2_z_q",      rsp_data,     D2);
    chk("t2_z_rspv",   p0_rsp_valid, 1'b0);

    // preload address 6 through port 1
    cyc();
    req1(1'b1, 1'b1, 14'h0006, D3, 16'hFFFF);
    settle();
    chk("pre_ready1",  p1_req_ready, 1'b1);
    chk("pre_a",       sram_a,       14'h0006);
    chk("pre_d",       sram_d,       D3);
    cyc();
    req1(1'b0, 1'b0, '0, '0, '0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;

    // ---------------- 3: alternating reads, one per cycle ----------------
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    req1(1'b1, 1'b0, 14'h0006, '0, '0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_ready0", p0_req_ready, (i % 2) == 0);
      chk("t3_ready1", p1_req_ready, (i % 2) == 1);
      chk("t3_cen",    sram_cen,     1'b0);
      chk("t3_a",      sram_a,       ((i % 2) == 0) ? 14'h0005 : 14'h0006);
      chk("t3_rspv0",  p0_rsp_valid, (i % 2) == 1);
      chk("t3_rspv1",  p1_rsp_valid, (i > 0) && ((i % 2) == 0));
      if (i > 0) chk("t3_data", rsp_data, ((i % 2) == 1) ? D2 : D3);
      cyc();
    end
    req0(1'b0, 1'b0, '0, '0, '0);
    req1(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t3_last_v1",   p1_rsp_valid, 1'b1);
    chk("t3_last_data", rsp_data,     D3);
    cyc();

    // ---------------- 4: blocked response ----------------
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    settle();
    chk("t4_rd_ready0", p0_req_ready, 1'b1);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    req1(1'b1, 1'b1, 14'h0007, D4, 16'hFFFF);
    settle();
    chk("t4_wr_ready1", p1_req_ready, 1'b1);
    chk("t4_wr_cen",    sram_cen,     1'b0);
    chk("t4_wr_wen",    sram_wen,     16'h0000);
    chk("t4_wr_rspv0",  p0_rsp_valid, 1'b1);
    cyc();
    req1(1'b1, 1'b0, 14'h0007, '0, '0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_blk_ready1", p1_req_ready, 1'b0);
      chk("t4_blk_cen",    sram_cen,     1'b1);
      chk("t4_blk_rspv0",  p0_rsp_valid, 1'b1);
      chk("t4_blk_data",   rsp_data,     D2);
      cyc();
    end
    p0_rsp_ready = 1'b1;
    settle();
    chk("t4_rel_ready1", p1_req_ready, 1'b1);
    chk("t4_rel_cen",    sram_cen,     1'b0);
    chk("t4_rel_a",      sram_a,       14'h0007);
    cyc();
    req1(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t4_rsp_v1",   p1_rsp_valid, 1'b1);
    chk("t4_rsp_v0",   p0_rsp_valid, 1'b0);
    chk("t4_rsp_data", rsp_data,     D4);
    p1_rsp_ready = 1'b1;
    cyc();

    // ---------------- 5: top address, read-after-write ----------------
    req0(1'b1, 1'b1, 14'h3FFF, D5, 16'hFFFF);
    settle();
    chk("t5_wr_ready", p0_req_ready, 1'b1);
    chk("t5_wr_a",     sram_a,       14'h3FFF);
    chk("t5_wr_d",     sram_d,       D5);
    cyc();
    req0(1'b1, 1'b0, 14'h3FFF, '0, '0);
    settle();
    chk("t5_rd_ready", p0_req_ready, 1'b1);
    chk("t5_rd_wen",   sram_wen,     16'hFFFF);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t5_rsp_v0",   p0_rsp_valid, 1'b1);
    chk("t5_rsp_data", rsp_data,     D5);
    cyc();

    // ---------------- 6: reset with a pending response ----------------
    p1_rsp_ready = 1'b0;
    req1(1'b1, 1'b0, 14'h0006, '0, '0);
    settle();
    chk("t6_rd_ready1", p1_req_ready, 1'b1);
    cyc();
    req1(1'b0, 1'b0, '0, '0, '0);
    req0(1'b1, 1'b1, 14'h0008, D4, 16'hFFFF);
    settle();
    chk("t6_wr_ready0", p0_req_ready, 1'b1);
    chk("t6_pend_v1",   p1_rsp_valid, 1'b1);
    chk("t6_pend_data", rsp_data,     D3);
    cyc();
    RST = 1'b1;
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    settle();
    chk("t6_rst_ready0", p0_req_ready, 1'b0);
    chk("t6_rst_cen",    sram_cen,     1'b1);
    cyc();
    RST = 1'b0;
    req0(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t6_after_v1",  p1_rsp_valid, 1'b0);
    chk("t6_after_v0",  p0_rsp_valid, 1'b0);
    chk("t6_after_cen", sram_cen,     1'b1);
    cyc();
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    req0(1'b1, 1'b0, 14'h0005, '0, '0);
    req1(1'b1, 1'b0, 14'h0006, '0, '0);
    settle();
    chk("t6_rr_ready0", p0_req_ready, 1'b1);
    chk("t6_rr_ready1", p1_req_ready, 1'b0);
    cyc();
    settle();
    chk("t6_nx_ready1", p1_req_ready, 1'b1);
    chk("t6_nx_rspv0",  p0_rsp_valid, 1'b1);
    chk("t6_nx_data",   rsp_data,     D2);
    cyc();
    req0(1'b0, 1'b0, '0, '0, '0);
    req1(1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t6_end_rspv1", p1_rsp_valid, 1'b1);
    chk("t6_end_data",  rsp_data,     D3);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
